// File: rtl/tb_req_gen.sv
// tb_req_gen: bench traffic source for the DRAM controller request queue.
//
// Emits a write phase of num_req requests followed by a read phase of
// num_req requests to the same addresses. Each item is {cmd, addr, data}
// with cmd 1 = write, 0 = read. data = {index, addr}, so a read carries
// exactly the value its matching write stored and can serve as the
// expected data for a downstream checker.
//
// Address patterns: sequential (base_addr + i*STRIDE, wrapping) or random
// (low ADDR_W bits of a 16-bit Fibonacci LFSR, taps 16,14,13,11, stepped
// once per accepted item and restarted from SEED at each phase).
//
// Handshake: an item transfers on a rising edge where o_v=1 and o_b=0.
// While o_v=1 and o_b=1 the item (o_d) is held unchanged, and o_v is never
// withdrawn before the item transfers.
//
// Compile-time option: TB_REQGEN_THROTTLE_EN
//   defined   - after every accept, o_v stays low for GAP cycles before the
//               next item is presented.
//   undefined - items are presented back-to-back.
//
// Ports:
//   clock      clock
//   reset      asynchronous, active-low reset
//   start      one-cycle launch pulse, ignored while a run is in progress
//   mode       0 = sequential, 1 = LFSR random (sampled on start)
//   base_addr  sequential start address (sampled on start)
//   num_req    writes per run, reads per run equal (sampled on start)
//   o_d        {cmd, addr, data}
//   o_v        item valid
//   o_b        downstream back-pressure
//   busy       run in progress (cycle after start through the done cycle)
//   done       one-cycle pulse after the last read is accepted
//   wr_cnt     writes accepted this run
//   rd_cnt     reads accepted this run
module tb_req_gen #(
  parameter int          ADDR_W = 16,
  parameter int          DATA_W = 32,
  parameter int          CNT_W  = 16,
  parameter int          STRIDE = 1,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          GAP    = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [CNT_W-1:0]           num_req,
  output logic [1+ADDR_W+DATA_W-1:0] o_d,
  output logic                       o_v,
  input  logic                       o_b,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           wr_cnt,
  output logic [CNT_W-1:0]           rd_cnt
);

  localparam int OW = 1 + ADDR_W + DATA_W;
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

`ifdef TB_REQGEN_THROTTLE_EN
  localparam logic [3:0] GAP_C = 4'(GAP);
`else
  // Back-to-back presentation: the idle gap is forced to zero.
  localparam logic [3:0] GAP_C = 4'(GAP) & 4'h0;
`endif

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t            state;
  logic              mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  idx;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       lfsr;
  logic [3:0]        gap_cnt;

  logic              accept;
  logic              last_item;
  logic [CNT_W-1:0]  idx_next;
  logic [15:0]       lfsr_next;
  logic [ADDR_W-1:0] addr_step;
  logic [ADDR_W-1:0] addr_first;
  logic [ADDR_W-1:0] start_addr;

  assign accept     = o_v & ~o_b;
  assign last_item  = (idx == num_q - CNT_W'(1));
  assign idx_next   = idx + CNT_W'(1);
  // Right-shifting Fibonacci form; taps 16,14,13,11 sit at bits 0,2,3,5.
  assign lfsr_next  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign addr_step  = mode_q ? lfsr_next[ADDR_W-1:0] : addr_q + ADDR_W'(STRIDE);
  assign addr_first = mode_q ? SEED_EFF[ADDR_W-1:0] : base_q;
  assign start_addr = mode ? SEED_EFF[ADDR_W-1:0] : base_addr;

  // {cmd, addr, {index, addr}}; the index is truncated or zero-extended to
  // fill the bits of the data field above the address.
  function automatic logic [OW-1:0] make_item(input logic cmd,
                                              input logic [CNT_W-1:0] i,
                                              input logic [ADDR_W-1:0] a);
    logic [DATA_W+CNT_W-1:0] wide;
    wide = ({{DATA_W{1'b0}}, i} << ADDR_W) | {{(DATA_W+CNT_W-ADDR_W){1'b0}}, a};
    return {cmd, a, wide[DATA_W-1:0]};
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      o_v     <= 1'b0;
      o_d     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      lfsr    <= SEED_EFF;
      idx     <= '0;
      addr_q  <= '0;
      mode_q  <= 1'b0;
      base_q  <= '0;
      num_q   <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q  <= mode;
            base_q  <= base_addr;
            num_q   <= num_req;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            idx     <= '0;
            lfsr    <= SEED_EFF;
            addr_q  <= start_addr;
            gap_cnt <= '0;
            busy    <= 1'b1;
            if (num_req == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WR;
              o_v   <= 1'b1;
              o_d   <= make_item(1'b1, '0, start_addr);
            end
          end
        end

        WR, RD: begin
          if (accept) begin
            if (state == WR) begin
              if (wr_cnt != num_q) wr_cnt <= wr_cnt + CNT_W'(1);
            end else begin
              if (rd_cnt != num_q) rd_cnt <= rd_cnt + CNT_W'(1);
            end
            gap_cnt <= GAP_C;
            o_v     <= (GAP_C == 4'd0);
            if (last_item && state == RD) begin
              state <= DONE;
              o_v   <= 1'b0;
              done  <= 1'b1;
            end else if (last_item) begin
              // Read phase replays the write addresses from the start.
              state  <= RD;
              idx    <= '0;
              addr_q <= addr_first;
              lfsr   <= SEED_EFF;
              o_d    <= make_item(1'b0, '0, addr_first);
            end else begin
              idx    <= idx_next;
              addr_q <= addr_step;
              if (mode_q) lfsr <= lfsr_next;
              o_d    <= make_item(state == WR, idx_next, addr_step);
            end
          end else if (!o_v) begin
            // Throttle gap: the next item is already in o_d, just hidden.
            if (gap_cnt <= 4'd1) begin
              o_v     <= 1'b1;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_req_gen.sv
// Bench for tb_req_gen: table of directed runs with known addresses,
// hand-written back-pressure / empty-run / mid-run-reset sequences, and
// randomized runs checked item-by-item against a reference model.
module tb_tb_req_gen;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int STRIDE = 1;
  localparam int OW     = 1 + ADDR_W + DATA_W;
`ifdef TB_REQGEN_THROTTLE_EN
  localparam int GAP_EXP = 3;
`else
  localparam int GAP_EXP = 0;
`endif

  logic              clock;
  logic              reset;
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_req;
  logic [OW-1:0]     o_d;
  logic              o_v;
  logic              o_b;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;

  tb_req_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .STRIDE(STRIDE), .SEED(16'hACE1), .GAP(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .num_req(num_req), .o_d(o_d), .o_v(o_v),
    .o_b(o_b), .busy(busy), .done(done), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [OW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] acc_addr[$];
  bit                mon_en    = 1'b0;
  bit                hold_prev = 1'b0;
  bit                seen_acc  = 1'b0;
  int                idle_cnt  = 0;
  logic [OW-1:0]     prev_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference LFSR: one step of a 16-bit Fibonacci register with taps
  // 16,14,13,11, shifting toward bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int   taps[4] = '{16, 14, 13, 11};
    logic fb;
    fb = 1'b0;
    foreach (taps[k]) fb = fb ^ s[16 - taps[k]];
    return {fb, s[15:1]};
  endfunction

  task automatic push_model(input bit m, input logic [15:0] base, input int n);
    logic [15:0] l;
    logic [15:0] a;
    logic [31:0] d;
    for (int ph = 0; ph < 2; ph++) begin
      l = 16'hACE1;
      for (int i = 0; i < n; i++) begin
        a = m ? l : 16'(base + i * STRIDE);
        l = lfsr_step(l);
        d = {16'(i), a};
        exp_q.push_back({(ph == 0), a, d});
      end
    end
  endtask

  // Monitor: samples on the falling edge, where inputs and outputs are
  // stable for the following rising edge.
  always @(negedge clock) begin
    if (mon_en && reset) begin
      if (hold_prev) begin
        check("hold_valid", 64'(o_v), 64'd1);
        check("hold_data", 64'(o_d), 64'(prev_d));
      end
      if (o_v && !o_b) begin
        if (seen_acc) check("gap_len", 64'(idle_cnt), 64'(GAP_EXP));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_item: got %0h expected none", o_d);
        end else begin
          check("item", 64'(o_d), 64'(exp_q.pop_front()));
        end
        acc_addr.push_back(o_d[DATA_W+ADDR_W-1:DATA_W]);
        seen_acc = 1'b1;
        idle_cnt = 0;
      end else if (!o_v) begin
        idle_cnt++;
      end
      hold_prev = o_v && o_b;
      prev_d    = o_d;
    end
  end

  // ---------------- driver ----------------
  // stall: 0 none, 1 o_b high in cycles 2-5, 2 random back-pressure.
  // poke: re-pulse start mid-run with junk settings (must be ignored).
  task automatic run(input bit m, input logic [15:0] base, input int n,
                     input int stall, input bit poke, output int done_at);
    exp_q.delete();
    acc_addr.delete();
    seen_acc  = 1'b0;
    idle_cnt  = 0;
    hold_prev = 1'b0;
    push_model(m, base, n);
    mon_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b1; mode = m; base_addr = base; num_req = CNT_W'(n); o_b = 1'b0;
    @(posedge clock); #1;
    start = 1'b0; mode = ~m; base_addr = 16'($urandom); num_req = CNT_W'($urandom_range(1, 9));
    done_at = -1;
    for (int k = 1; k <= 400; k++) begin
      case (stall)
        1:       o_b = (k >= 2 && k <= 5);
        2:       o_b = ($urandom_range(0, 2) == 0);
        default: o_b = 1'b0;
      endcase
      start = poke && (k == 3);
      @(negedge clock);
      if (k == 1 && n > 0) check("busy_running", 64'(busy), 64'd1);
      if (stall == 1 && k >= 2 && k <= 5)
        check("bp_frozen", 64'(o_d), 64'({1'b1, 16'h0011, 32'h0001_0011}));
      if (done) begin
        done_at = k;
        break;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    o_b   = 1'b0;
    if (done_at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
    check("done_ov_low", 64'(o_v), 64'd0);
    check("wr_cnt", 64'(wr_cnt), 64'(n));
    check("rd_cnt", 64'(rd_cnt), 64'(n));
    check("items_left", 64'(exp_q.size()), 64'd0);
    @(posedge clock); #1;
    check("done_pulse_end", 64'(done), 64'd0);
    check("busy_end", 64'(busy), 64'd0);
    check("counts_hold", 64'(wr_cnt), 64'(n));
    mon_en = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          m;
    logic [15:0] base;
    int          n;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] a2;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int d_at;
    bit found;

    vecs[0] = '{m: 1'b0, base: 16'h0010, n: 4, a0: 16'h0010, a1: 16'h0011, a2: 16'h0012};
    vecs[1] = '{m: 1'b0, base: 16'hFFFE, n: 3, a0: 16'hFFFE, a1: 16'hFFFF, a2: 16'h0000};
    vecs[2] = '{m: 1'b1, base: 16'h1234, n: 3, a0: 16'hACE1, a1: 16'h5670, a2: 16'hAB38};

    reset = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; num_req = '0; o_b = 1'b0;
    #22;
    check("rst_ov", 64'(o_v), 64'd0);
    check("rst_od", 64'(o_d), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    check("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[v]) begin
      run(vecs[v].m, vecs[v].base, vecs[v].n, 0, 1'b1, d_at);
      check("done_latency", 64'(d_at), 64'(1 + 2 * vecs[v].n + GAP_EXP * (2 * vecs[v].n - 1)));
      check("acc_count", 64'(acc_addr.size()), 64'(2 * vecs[v].n));
      if (acc_addr.size() == 2 * vecs[v].n) begin
        check("wr_addr0", 64'(acc_addr[0]), 64'(vecs[v].a0));
        check("wr_addr1", 64'(acc_addr[1]), 64'(vecs[v].a1));
        check("wr_addr2", 64'(acc_addr[2]), 64'(vecs[v].a2));
        check("rd_addr0", 64'(acc_addr[vecs[v].n]), 64'(vecs[v].a0));
        check("rd_addr1", 64'(acc_addr[vecs[v].n + 1]), 64'(vecs[v].a1));
        check("rd_addr2", 64'(acc_addr[vecs[v].n + 2]), 64'(vecs[v].a2));
      end
    end

    // Back-pressure in cycles 2-5: second write held, nothing lost or doubled.
    run(1'b0, 16'h0010, 4, 1, 1'b0, d_at);
`ifndef TB_REQGEN_THROTTLE_EN
    check("bp_done_latency", 64'(d_at), 64'd13);
`endif
    check("bp_acc_count", 64'(acc_addr.size()), 64'd8);

    // Empty run: done the cycle after start, never a valid item.
    run(1'b0, 16'h0100, 0, 0, 1'b0, d_at);
    check("empty_done_latency", 64'(d_at), 64'd1);
    check("empty_no_items", 64'(acc_addr.size()), 64'd0);

    // Reset during the read phase aborts immediately.
    @(posedge clock); #1;
    start = 1'b1; mode = 1'b0; base_addr = 16'h0040; num_req = 16'd4;
    @(posedge clock); #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (o_v && !o_d[OW-1]) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_read_phase", 64'(found), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ov", 64'(o_v), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_rd_cnt", 64'(rd_cnt), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    run(1'b1, 16'h0000, 3, 0, 1'b0, d_at);
    check("post_reset_first_addr", 64'(acc_addr.size() > 0 ? acc_addr[0] : 16'h0000), 64'h0000_ACE1);

    // Randomized runs with random back-pressure.
    for (int r = 0; r < 8; r++) begin
      run(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 6), 2,
          1'($urandom_range(0, 1)), d_at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
